// File: rtl/pwm_duty_seq_pkg.sv
// Shared types and defaults for the pwm_duty_seq pattern sequencer.
// Optional sticky done flag is enabled by PWM_DUTY_SEQ_DONE_EN.
package pwm_duty_seq_pkg;

    localparam int unsigned SeqNEntries = 8;
    localparam int unsigned SeqDutyDw   = 16;
    localparam int unsigned SeqHoldDw   = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } seq_state_e;

    typedef struct packed {
        logic [SeqDutyDw-1:0] duty;
        logic [SeqHoldDw-1:0] hold;
    } seq_entry_t;

    localparam logic [SeqDutyDw-1:0] SeqIdleDuty = '0;

endpackage

// File: rtl/pwm_duty_seq_fsm.sv
// Sequencer control: state, entry index and hold counter.
// PWM_DUTY_SEQ_DONE_EN adds the sticky completion flag.
module pwm_duty_seq_fsm
    import pwm_duty_seq_pkg::*;
#(
    parameter int unsigned IdxW   = 3,
    parameter int unsigned HoldDw = SeqHoldDw
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              cycle_start,
    input  logic              loop,
    input  logic [IdxW-1:0]   last_idx,
    input  logic [HoldDw-1:0] cur_hold,
`ifdef PWM_DUTY_SEQ_DONE_EN
    input  logic              done_clr,
    output logic              done,
`endif
    output logic              load_en,
    output logic [IdxW-1:0]   load_idx,
    output logic              clr_en,
    output logic              busy,
    output logic [IdxW-1:0]   idx
);

    seq_state_e        state;
    logic [HoldDw-1:0] hold_cnt;
    logic [HoldDw-1:0] hold_eff;
    logic              hold_end;
    logic              at_last;
    logic              go;
    logic              run_ev;

    always_comb begin
        hold_eff = (cur_hold == '0) ? HoldDw'(1) : cur_hold;
        hold_end = cycle_start
                 && (hold_cnt == hold_eff - HoldDw'(1));
        at_last  = (idx == last_idx);
        go       = (state == IDLE) && start && !stop;
        run_ev   = (state == RUN) && !stop && !pause
                 && hold_end;
        clr_en   = (state != IDLE) && stop;
        load_en  = go || (run_ev && (!at_last || loop));
        load_idx = (go || at_last) ? '0 : idx + IdxW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            hold_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state    <= RUN;
                        idx      <= '0;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state    <= IDLE;
                        idx      <= '0;
                        hold_cnt <= '0;
                        busy     <= 1'b0;
                    end else if (pause) begin
                        state <= PAUSED;
                    end else if (hold_end) begin
                        hold_cnt <= '0;
                        if (at_last && !loop) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx <= load_idx;
                        end
                    end else if (cycle_start) begin
                        hold_cnt <= hold_cnt + HoldDw'(1);
                    end
                end
                PAUSED: begin
                    if (stop) begin
                        state    <= IDLE;
                        idx      <= '0;
                        hold_cnt <= '0;
                        busy     <= 1'b0;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PWM_DUTY_SEQ_DONE_EN
    // Set on the non-looping completion edge; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else if (run_ev && at_last && !loop) begin
            done <= 1'b1;
        end else if (done_clr || go) begin
            done <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/pwm_duty_seq.sv
// Duty-cycle pattern sequencer feeding one pwm_core channel.
// Define PWM_DUTY_SEQ_DONE_EN to add done_o / done_clr_i.
module pwm_duty_seq
    import pwm_duty_seq_pkg::*;
#(
    parameter int unsigned NEntries = SeqNEntries,
    parameter int unsigned DutyDw   = SeqDutyDw,
    parameter int unsigned HoldDw   = SeqHoldDw,
    localparam int unsigned IdxW    = $clog2(NEntries)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tbl_we_i,
    input  logic [IdxW-1:0]   tbl_addr_i,
    input  logic [DutyDw-1:0] tbl_duty_i,
    input  logic [HoldDw-1:0] tbl_hold_i,
    input  logic [IdxW-1:0]   last_idx_i,
    input  logic              loop_i,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic              stop_i,
    input  logic              cycle_start_i,
`ifdef PWM_DUTY_SEQ_DONE_EN
    input  logic              done_clr_i,
    output logic              done_o,
`endif
    output logic [DutyDw-1:0] duty_o,
    output logic              duty_upd_o,
    output logic              busy_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [DutyDw-1:0] tbl_duty [NEntries];
    logic [HoldDw-1:0] tbl_hold [NEntries];
    logic              load_en;
    logic              clr_en;
    logic [IdxW-1:0]   load_idx;

    // Table is not reset; a load on a write edge sees the old entry.
    always_ff @(posedge clk_i) begin
        if (tbl_we_i) begin
            tbl_duty[tbl_addr_i] <= tbl_duty_i;
            tbl_hold[tbl_addr_i] <= tbl_hold_i;
        end
    end

    pwm_duty_seq_fsm #(
        .IdxW   (IdxW),
        .HoldDw (HoldDw)
    ) u_fsm (
        .clk         (clk_i),
        .rst         (rst_i),
        .start       (start_i),
        .stop        (stop_i),
        .pause       (pause_i),
        .cycle_start (cycle_start_i),
        .loop        (loop_i),
        .last_idx    (last_idx_i),
        .cur_hold    (tbl_hold[idx_o]),
`ifdef PWM_DUTY_SEQ_DONE_EN
        .done_clr    (done_clr_i),
        .done        (done_o),
`endif
        .load_en     (load_en),
        .load_idx    (load_idx),
        .clr_en      (clr_en),
        .busy        (busy_o),
        .idx         (idx_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            duty_o     <= DutyDw'(SeqIdleDuty);
            duty_upd_o <= 1'b0;
        end else begin
            duty_upd_o <= load_en | clr_en;
            if (clr_en) begin
                duty_o <= DutyDw'(SeqIdleDuty);
            end else if (load_en) begin
                duty_o <= tbl_duty[load_idx];
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_seq.sv
// Directed self-checking bench for pwm_duty_seq.
// Done-flag checks compile in when PWM_DUTY_SEQ_DONE_EN is defined.
module tb_pwm_duty_seq;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        tbl_we_i = 1'b0;
    logic [2:0]  tbl_addr_i = '0;
    logic [15:0] tbl_duty_i = '0;
    logic [7:0]  tbl_hold_i = '0;
    logic [2:0]  last_idx_i = '0;
    logic        loop_i = 1'b0;
    logic        start_i = 1'b0;
    logic        pause_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        cycle_start_i = 1'b0;
    logic [15:0] duty_o;
    logic        duty_upd_o;
    logic        busy_o;
    logic [2:0]  idx_o;
`ifdef PWM_DUTY_SEQ_DONE_EN
    logic        done_clr_i = 1'b0;
    logic        done_o;
`endif

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;

    pwm_duty_seq dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .tbl_we_i      (tbl_we_i),
        .tbl_addr_i    (tbl_addr_i),
        .tbl_duty_i    (tbl_duty_i),
        .tbl_hold_i    (tbl_hold_i),
        .last_idx_i    (last_idx_i),
        .loop_i        (loop_i),
        .start_i       (start_i),
        .pause_i       (pause_i),
        .stop_i        (stop_i),
        .cycle_start_i (cycle_start_i),
`ifdef PWM_DUTY_SEQ_DONE_EN
        .done_clr_i    (done_clr_i),
        .done_o        (done_o),
`endif
        .duty_o        (duty_o),
        .duty_upd_o    (duty_upd_o),
        .busy_o        (busy_o),
        .idx_o         (idx_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (duty_upd_o === 1'b1) upd_cnt = upd_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle9();
        repeat (9) tick();
    endtask

    task automatic pulse();
        cycle_start_i = 1'b1;
        tick();
        cycle_start_i = 1'b0;
    endtask

    task automatic wr(input int a, input int d, input int h);
        tbl_we_i   = 1'b1;
        tbl_addr_i = 3'(a);
        tbl_duty_i = 16'(d);
        tbl_hold_i = 8'(h);
        tick();
        tbl_we_i = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++;
        if (duty_o !== 16'd0 || duty_upd_o !== 1'b0
            || busy_o !== 1'b0 || idx_o !== 3'd0) begin
            failures++;
            $display("FAIL reset duty=%0d upd=%0b busy=%0b idx=%0d want 0/0/0/0",
                     duty_o, duty_upd_o, busy_o, idx_o);
        end
`ifdef PWM_DUTY_SEQ_DONE_EN
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%0b want=0", done_o);
        end
`endif
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_start_stop_idle();
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || duty_upd_o !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_idle busy=%0b upd=%0b want 0/0",
                     busy_o, duty_upd_o);
        end
        tick();
    endtask

    task automatic test_oneshot();
        wr(0, 100, 2);
        wr(1, 200, 1);
        wr(2, 300, 3);
        last_idx_i = 3'd2;
        loop_i = 1'b0;
        upd_cnt = 0;
        do_start();
        checks++;
        if (duty_o !== 16'd100 || duty_upd_o !== 1'b1
            || busy_o !== 1'b1 || idx_o !== 3'd0) begin
            failures++;
            $display("FAIL oneshot_start duty=%0d upd=%0b busy=%0b idx=%0d want 100/1/1/0",
                     duty_o, duty_upd_o, busy_o, idx_o);
        end
        for (int i = 1; i <= 6; i++) begin
            idle9();
            pulse();
            if (i == 1) begin
                checks++;
                if (duty_o !== 16'd100 || duty_upd_o !== 1'b0) begin
                    failures++;
                    $display("FAIL oneshot_p1 duty=%0d upd=%0b want 100/0",
                             duty_o, duty_upd_o);
                end
            end else if (i == 2) begin
                checks++;
                if (duty_o !== 16'd200 || duty_upd_o !== 1'b1
                    || idx_o !== 3'd1) begin
                    failures++;
                    $display("FAIL oneshot_p2 duty=%0d upd=%0b idx=%0d want 200/1/1",
                             duty_o, duty_upd_o, idx_o);
                end
            end else if (i == 3) begin
                checks++;
                if (duty_o !== 16'd300 || duty_upd_o !== 1'b1
                    || idx_o !== 3'd2) begin
                    failures++;
                    $display("FAIL oneshot_p3 duty=%0d upd=%0b idx=%0d want 300/1/2",
                             duty_o, duty_upd_o, idx_o);
                end
            end else if (i == 5) begin
                checks++;
                if (busy_o !== 1'b1) begin
                    failures++;
                    $display("FAIL oneshot_p5_busy got=%0b want=1", busy_o);
                end
            end
        end
        checks++;
        if (busy_o !== 1'b0 || duty_o !== 16'd300
            || duty_upd_o !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_end busy=%0b duty=%0d upd=%0b want 0/300/0",
                     busy_o, duty_o, duty_upd_o);
        end
        tick();
        checks++;
        if (upd_cnt != 3) begin
            failures++;
            $display("FAIL oneshot_upd_count got=%0d want=3", upd_cnt);
        end
`ifdef PWM_DUTY_SEQ_DONE_EN
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_done got=%0b want=1", done_o);
        end
`endif
    endtask

    task automatic test_loop();
        loop_i = 1'b1;
        do_start();
`ifdef PWM_DUTY_SEQ_DONE_EN
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL loop_start_clears_done got=%0b want=0", done_o);
        end
`endif
        for (int i = 1; i <= 6; i++) begin
            idle9();
            pulse();
        end
        checks++;
        if (idx_o !== 3'd0 || duty_o !== 16'd100
            || duty_upd_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL loop_wrap idx=%0d duty=%0d upd=%0b busy=%0b want 0/100/1/1",
                     idx_o, duty_o, duty_upd_o, busy_o);
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || duty_o !== 16'd0) begin
            failures++;
            $display("FAIL loop_stop busy=%0b duty=%0d want 0/0", busy_o, duty_o);
        end
        loop_i = 1'b0;
        tick();
    endtask

    task automatic test_hold_zero();
        wr(1, 200, 0);
        last_idx_i = 3'd1;
        do_start();
        idle9();
        pulse();
        idle9();
        pulse();
        checks++;
        if (idx_o !== 3'd1 || duty_o !== 16'd200) begin
            failures++;
            $display("FAIL hold0_enter idx=%0d duty=%0d want 1/200", idx_o, duty_o);
        end
        idle9();
        pulse();
        checks++;
        if (busy_o !== 1'b0 || duty_o !== 16'd200) begin
            failures++;
            $display("FAIL hold0_advance busy=%0b duty=%0d want 0/200", busy_o, duty_o);
        end
`ifdef PWM_DUTY_SEQ_DONE_EN
        done_clr_i = 1'b1;
        tick();
        done_clr_i = 1'b0;
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL done_clear got=%0b want=0", done_o);
        end
`endif
        tick();
    endtask

    task automatic test_pause();
        wr(0, 100, 4);
        last_idx_i = 3'd0;
        loop_i = 1'b0;
        do_start();
        idle9();
        pulse();
        idle9();
        pulse();
        pause_i = 1'b1;
        tick();
        upd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            idle9();
            pulse();
        end
        checks++;
        if (busy_o !== 1'b1 || idx_o !== 3'd0 || upd_cnt != 0) begin
            failures++;
            $display("FAIL pause_frozen busy=%0b idx=%0d upd=%0d want 1/0/0",
                     busy_o, idx_o, upd_cnt);
        end
        pause_i = 1'b0;
        tick();
        idle9();
        pulse();
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL pause_resume_early busy=%0b want=1", busy_o);
        end
        idle9();
        pulse();
        checks++;
        if (busy_o !== 1'b0 || duty_o !== 16'd100) begin
            failures++;
            $display("FAIL pause_resume_end busy=%0b duty=%0d want 0/100",
                     busy_o, duty_o);
        end
        tick();
    endtask

    task automatic test_stop_final();
        do_start();
        for (int i = 0; i < 3; i++) begin
            idle9();
            pulse();
        end
        idle9();
        upd_cnt = 0;
        stop_i = 1'b1;
        cycle_start_i = 1'b1;
        tick();
        stop_i = 1'b0;
        cycle_start_i = 1'b0;
        checks++;
        if (duty_o !== 16'd0 || duty_upd_o !== 1'b1
            || idx_o !== 3'd0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL stop_final duty=%0d upd=%0b idx=%0d busy=%0b want 0/1/0/0",
                     duty_o, duty_upd_o, idx_o, busy_o);
        end
        tick();
        tick();
        checks++;
        if (upd_cnt != 1) begin
            failures++;
            $display("FAIL stop_upd_count got=%0d want=1", upd_cnt);
        end
`ifdef PWM_DUTY_SEQ_DONE_EN
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL stop_no_done got=%0b want=0", done_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        wr(0, 100, 2);
        wr(1, 200, 1);
        wr(2, 300, 3);
        last_idx_i = 3'd2;
        loop_i = 1'b1;
        do_start();
        idle9();
        pulse();
        idle9();
        cycle_start_i = 1'b1;
        tbl_we_i   = 1'b1;
        tbl_addr_i = 3'd1;
        tbl_duty_i = 16'd555;
        tbl_hold_i = 8'd1;
        tick();
        cycle_start_i = 1'b0;
        tbl_we_i = 1'b0;
        checks++;
        if (duty_o !== 16'd200 || idx_o !== 3'd1) begin
            failures++;
            $display("FAIL rbw_old duty=%0d idx=%0d want 200/1", duty_o, idx_o);
        end
        idle9();
        pulse();
        checks++;
        if (duty_o !== 16'd300 || idx_o !== 3'd2) begin
            failures++;
            $display("FAIL rbw_e2 duty=%0d idx=%0d want 300/2", duty_o, idx_o);
        end
        for (int i = 0; i < 3; i++) begin
            idle9();
            pulse();
        end
        checks++;
        if (duty_o !== 16'd100 || idx_o !== 3'd0) begin
            failures++;
            $display("FAIL rbw_wrap duty=%0d idx=%0d want 100/0", duty_o, idx_o);
        end
        idle9();
        pulse();
        idle9();
        pulse();
        checks++;
        if (duty_o !== 16'd555 || idx_o !== 3'd1 || duty_upd_o !== 1'b1) begin
            failures++;
            $display("FAIL rbw_new duty=%0d idx=%0d upd=%0b want 555/1/1",
                     duty_o, idx_o, duty_upd_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if (duty_o !== 16'd0 || duty_upd_o !== 1'b0
            || busy_o !== 1'b0 || idx_o !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset duty=%0d upd=%0b busy=%0b idx=%0d want 0/0/0/0",
                     duty_o, duty_upd_o, busy_o, idx_o);
        end
        loop_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_start_stop_idle();
        test_oneshot();
        test_loop();
        test_hold_zero();
        test_pause();
        test_stop_final();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
